cmos_cfg_sequencer: RTL
=======================

CMOS_CFG_SEQUENCER -- requirements
Module: cmos_cfg_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - CLOCK_MAIN, 200_000, sys_clk frequency in kHz, equal to cycles per ms.
  - LUT_SIZE, 256, number of table entries, 2..256.
  - PWDN_MS, 5, power-down hold time in ms.
  - RST_MS, 1, reset-low hold time in ms.
  - RUN_MS, 20, settle time after reset release in ms.
  - RETRY_MAX, 3, retries per entry.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - sys_clk, in, 1, the single clock.
  - sys_rst, in, 1, synchronous active-high reset.
  - start, in, 1, single-cycle request to run the sequence.
  - cmos_pwdn, out, 1, sensor power-down, active-high.
  - cmos_reset, out, 1, sensor reset, active-low.
  - lut_index, out, 8, table address.
  - lut_data, in, 32, table entry; see REQ-003.
  - i2c_req, out, 1, write request to the I2C master.
  - i2c_addr, out, 16, sensor register address.
  - i2c_wdata, out, 8, register data.
  - i2c_ack, in, 1, one-cycle pulse: write completed.
  - i2c_nack, in, 1, one-cycle pulse: write failed.
  - busy, out, 1, sequence in progress.
  - config_done, out, 1, sequence completed.
  - config_err, out, 1, sequence aborted.
  - err_index, out, 8, index of the failing entry.
REQ-003 Table entries SHALL use this format:
  - lut_data[31:24] selects the entry type: 0x00 = write, 0x01 = delay, 0xFF = end; any other value = error.
  - For a write entry, [23:8] is the register address and [7:0] is the data.
  - For a delay entry, [15:0] is the delay in ms.

Function
REQ-004 The state machine SHALL have the states IDLE, PWDN_HOLD, RST_HOLD, RUN_WAIT, FETCH, DECODE, ISSUE, WAIT_RESP, DELAY, DONE and ERROR.
REQ-005 A start pulse in IDLE, DONE or ERROR SHALL load the following on the next edge:
  - state PWDN_HOLD, lut_index 0, busy 1;
  - config_done 0, config_err 0.
  A start pulse in any other state SHALL be ignored.
REQ-006 PWDN_HOLD SHALL drive cmos_pwdn=1 and cmos_reset=0 for exactly PWDN_MS*CLOCK_MAIN cycles.
REQ-007 RST_HOLD SHALL drive cmos_pwdn=0 and cmos_reset=0 for exactly RST_MS*CLOCK_MAIN cycles.
REQ-008 RUN_WAIT SHALL drive cmos_reset=1 for RUN_MS*CLOCK_MAIN cycles and then go to FETCH.
REQ-009 Millisecond timing SHALL use a cycle counter (0..CLOCK_MAIN-1) plus a 16-bit ms counter, with no drift across the ms boundary.
REQ-010 FETCH SHALL last one cycle, because the table is a synchronous ROM; DECODE SHALL sample lut_data.
REQ-011 A write entry SHALL move to ISSUE. ISSUE SHALL:
  - register i2c_addr and i2c_wdata;
  - assert i2c_req the following cycle;
  - hold i2c_req, i2c_addr and i2c_wdata stable until i2c_ack or i2c_nack.
REQ-012 An i2c_ack in WAIT_RESP SHALL deassert i2c_req on the next edge and advance to the next entry.
REQ-013 Advancing SHALL increment lut_index and go to FETCH. If lut_index is LUT_SIZE-1, advancing SHALL instead go to DONE without wrapping the index.
REQ-014 A delay entry SHALL wait exactly N*CLOCK_MAIN cycles in DELAY and then advance. N=0 SHALL advance immediately.
REQ-015 An end entry SHALL go to DONE: config_done=1 and busy=0, held until the next start pulse.
REQ-016 An unknown entry type SHALL go to ERROR: config_err=1, busy=0, err_index=lut_index.
REQ-017 i2c_ack and i2c_nack asserted in the same cycle SHALL be treated as a nack.
REQ-018 i2c_ack or i2c_nack received outside WAIT_RESP SHALL be ignored.
REQ-019 After DONE or ERROR, cmos_pwdn=0 and cmos_reset=1 SHALL persist.

Reset
REQ-020 With sys_rst high at a clock edge, the block SHALL load:
  - state IDLE;
  - cmos_pwdn=1, cmos_reset=0;
  - i2c_req=0, i2c_addr=0, i2c_wdata=0, lut_index=0;
  - busy=0, config_done=0, config_err=0, err_index=0;
  - all counters 0.
REQ-021 Reset mid-operation, including while i2c_req is high, SHALL drop i2c_req in that same cycle. The block SHALL NOT resume; a new start pulse is required.

Configuration
REQ-022 The macro CMOS_CFG_RETRY_EN SHALL control nack retry behaviour.
  - Defined: a nack SHALL re-issue the same entry after one idle cycle, up to RETRY_MAX retries. The retry counter SHALL reset for each new entry. The (RETRY_MAX+1)th nack SHALL go to ERROR with err_index=lut_index.
  - Undefined: the first nack SHALL go to ERROR, and no retry logic SHALL be synthesized.

Verification
Benches SHALL use CLOCK_MAIN=10, PWDN_MS=2, RST_MS=1, RUN_MS=2 and SHALL cover the following scenarios:
REQ-023 Power-up timing: start pulse -> cmos_pwdn high for exactly 20 cycles; cmos_reset low for a further 10 cycles; first FETCH 20 cycles after cmos_reset rises.
REQ-024 Write and delay: table {W 0x3008/0x82, D 3, W 0x3103/0x11, END}, with ack 4 cycles after each req -> i2c_addr 0x3008 then 0x3103, the second req 30+ cycles after the first ack, then config_done=1 and busy=0.
REQ-025 Retry with CMOS_CFG_RETRY_EN, RETRY_MAX=3: entry 2 nacked twice then acked -> three reqs with identical addr/data, then done. Entry nacked 4 times -> config_err=1, err_index=2.
REQ-026 Without CMOS_CFG_RETRY_EN: a single nack on entry 0 -> config_err=1, err_index=0, i2c_req=0.
REQ-027 Boundaries:
  - Simultaneous ack and nack -> handled as a nack.
  - Entry type 0x42 at index 5 -> ERROR with err_index=5.
  - LUT_SIZE=4 with no end entry -> DONE after index 3.
  - start while busy -> no effect.
  - sys_rst during WAIT_RESP -> i2c_req=0 and IDLE next cycle.

Source files
------------

// File: rtl/cmos_cfg_sequencer.sv
// CMOS sensor power-up and register-table sequencer: power-down/reset timing, then walks a
// synchronous ROM issuing I2C writes and ms delays. Define CMOS_CFG_RETRY_EN for nack retries.
module cmos_cfg_sequencer #(
  parameter int unsigned CLOCK_MAIN = 200_000,
  parameter int unsigned LUT_SIZE   = 256,
  parameter int unsigned PWDN_MS    = 5,
  parameter int unsigned RST_MS     = 1,
  parameter int unsigned RUN_MS     = 20,
  parameter int unsigned RETRY_MAX  = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  output logic        cmos_pwdn,
  output logic        cmos_reset,
  output logic [7:0]  lut_index,
  input  logic [31:0] lut_data,
  output logic        i2c_req,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_wdata,
  input  logic        i2c_ack,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        config_done,
  output logic        config_err,
  output logic [7:0]  err_index
);

  localparam int unsigned CycW = (CLOCK_MAIN > 1) ? $clog2(CLOCK_MAIN) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(CLOCK_MAIN - 1);
  localparam logic [7:0] IdxLast = 8'(LUT_SIZE - 1);

  localparam logic [7:0] TypeWrite = 8'h00;
  localparam logic [7:0] TypeDelay = 8'h01;
  localparam logic [7:0] TypeEnd   = 8'hFF;

  // Parameters outside these ranges are not supported; nothing is built for them.
  if ((LUT_SIZE < 2) || (LUT_SIZE > 256) || (RETRY_MAX > 255) || (CLOCK_MAIN < 1))
  begin : g_unsupported_cfg
  end

  typedef enum logic [3:0] {
    StIdle,
    StPwdnHold,
    StRstHold,
    StRunWait,
    StFetch,
    StDecode,
    StIssue,
    StWaitResp,
    StDelay,
    StDone,
    StError
  } state_e;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [15:0]     ms_q, ms_d;
  logic [15:0]     delay_q, delay_d;
  logic            cmos_pwdn_q, cmos_pwdn_d;
  logic            cmos_reset_q, cmos_reset_d;
  logic [7:0]      lut_index_q, lut_index_d;
  logic            i2c_req_q, i2c_req_d;
  logic [15:0]     i2c_addr_q, i2c_addr_d;
  logic [7:0]      i2c_wdata_q, i2c_wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      err_index_q, err_index_d;

`ifdef CMOS_CFG_RETRY_EN
  localparam int unsigned RetryW = $clog2(RETRY_MAX + 2);
  localparam logic [RetryW-1:0] RetryLast = RetryW'(RETRY_MAX);
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  logic [15:0] ms_target;
  logic        tick;
  logic        tm_done;
  logic        advance;
  logic        go_err;
  logic [7:0]  entry_type;

  assign entry_type = lut_data[31:24];
  assign tick       = (cyc_q == CycLast);

  always_comb begin
    ms_target = delay_q;
    case (state_q)
      StPwdnHold: ms_target = 16'(PWDN_MS);
      StRstHold:  ms_target = 16'(RST_MS);
      StRunWait:  ms_target = 16'(RUN_MS);
      default:    ms_target = delay_q;
    endcase
  end

  assign tm_done = tick && (ms_q == ms_target - 16'd1);

  always_comb begin
    state_d      = state_q;
    cyc_d        = '0;
    ms_d         = '0;
    delay_d      = delay_q;
    cmos_pwdn_d  = cmos_pwdn_q;
    cmos_reset_d = cmos_reset_q;
    lut_index_d  = lut_index_q;
    i2c_req_d    = i2c_req_q;
    i2c_addr_d   = i2c_addr_q;
    i2c_wdata_d  = i2c_wdata_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    err_index_d  = err_index_q;
    advance      = 1'b0;
    go_err       = 1'b0;
`ifdef CMOS_CFG_RETRY_EN
    retry_d      = retry_q;
`endif

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d      = StPwdnHold;
          lut_index_d  = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          err_d        = 1'b0;
          cmos_pwdn_d  = 1'b1;
          cmos_reset_d = 1'b0;
        end
      end
      StPwdnHold, StRstHold, StRunWait, StDelay: begin
        if (tm_done) begin
          unique case (state_q)
            StPwdnHold: begin
              state_d     = StRstHold;
              cmos_pwdn_d = 1'b0;
            end
            StRstHold: begin
              state_d      = StRunWait;
              cmos_reset_d = 1'b1;
            end
            StRunWait: state_d = StFetch;
            default:   advance = 1'b1;
          endcase
        end else begin
          // ms counter steps only when the cycle counter wraps, so no drift builds up.
          cyc_d = tick ? '0 : cyc_q + 1'b1;
          ms_d  = tick ? ms_q + 16'd1 : ms_q;
        end
      end
      StFetch: begin
        state_d = StDecode;
`ifdef CMOS_CFG_RETRY_EN
        retry_d = '0;
`endif
      end
      StDecode: begin
        case (entry_type)
          TypeWrite: state_d = StIssue;
          TypeDelay: begin
            if (lut_data[15:0] == 16'd0) begin
              advance = 1'b1;
            end else begin
              delay_d = lut_data[15:0];
              state_d = StDelay;
            end
          end
          TypeEnd: begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: go_err = 1'b1;
        endcase
      end
      StIssue: begin
        // The ROM output is still addressed by lut_index, so a retry re-reads the same entry.
        i2c_addr_d  = lut_data[23:8];
        i2c_wdata_d = lut_data[7:0];
        i2c_req_d   = 1'b1;
        state_d     = StWaitResp;
      end
      StWaitResp: begin
        if (i2c_nack) begin
          i2c_req_d = 1'b0;
`ifdef CMOS_CFG_RETRY_EN
          if (retry_q == RetryLast) begin
            go_err = 1'b1;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StIssue;
          end
`else
          go_err = 1'b1;
`endif
        end else if (i2c_ack) begin
          i2c_req_d = 1'b0;
          advance   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (lut_index_q == IdxLast) begin
        state_d = StDone;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        lut_index_d = lut_index_q + 8'd1;
        state_d     = StFetch;
      end
    end

    if (go_err) begin
      state_d     = StError;
      i2c_req_d   = 1'b0;
      busy_d      = 1'b0;
      err_d       = 1'b1;
      err_index_d = lut_index_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      cyc_q        <= '0;
      ms_q         <= '0;
      delay_q      <= '0;
      cmos_pwdn_q  <= 1'b1;
      cmos_reset_q <= 1'b0;
      lut_index_q  <= '0;
      i2c_req_q    <= 1'b0;
      i2c_addr_q   <= '0;
      i2c_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_index_q  <= '0;
`ifdef CMOS_CFG_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      ms_q         <= ms_d;
      delay_q      <= delay_d;
      cmos_pwdn_q  <= cmos_pwdn_d;
      cmos_reset_q <= cmos_reset_d;
      lut_index_q  <= lut_index_d;
      i2c_req_q    <= i2c_req_d;
      i2c_addr_q   <= i2c_addr_d;
      i2c_wdata_q  <= i2c_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_index_q  <= err_index_d;
`ifdef CMOS_CFG_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  // Reset removes the request combinationally so the I2C master never sees it in the reset cycle.
  assign i2c_req     = i2c_req_q & ~sys_rst;
  assign cmos_pwdn   = cmos_pwdn_q;
  assign cmos_reset  = cmos_reset_q;
  assign lut_index   = lut_index_q;
  assign i2c_addr    = i2c_addr_q;
  assign i2c_wdata   = i2c_wdata_q;
  assign busy        = busy_q;
  assign config_done = done_q;
  assign config_err  = err_q;
  assign err_index   = err_index_q;

endmodule
